// File: rtl/sodor_scratchpad_2stage.sv
// Scratchpad data memory behind the 2-stage router's scratch port.
// Byte/half/word access with sign/zero extension, one-cycle response, error flag.
module sodor_scratchpad_2stage #(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned SIZE_BYTES = 262144,
    parameter bit          INIT_ZERO  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    input  logic [31:0] io_req_bits_addr,
    input  logic [31:0] io_req_bits_data,
    input  logic        io_req_bits_fcn,
    input  logic [2:0]  io_req_bits_typ,
    output logic        io_resp_valid,
    output logic [31:0] io_resp_bits_data,
    output logic        io_resp_err
);

    localparam int unsigned AW      = $clog2(SIZE_BYTES);
    localparam int unsigned IW      = AW - 2;
    localparam int unsigned DEPTH   = SIZE_BYTES / 4;
    localparam logic [31:0] HI_MASK = ~(32'(SIZE_BYTES) - 32'd1);

    localparam logic [2:0] TYP_B  = 3'd1;
    localparam logic [2:0] TYP_H  = 3'd2;
    localparam logic [2:0] TYP_W  = 3'd3;
    localparam logic [2:0] TYP_BU = 3'd5;
    localparam logic [2:0] TYP_HU = 3'd6;

    // Contents at time 0 are zero or undefined; reset never touches the array.
    logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx)};

    logic          resp_valid_q, resp_valid_d;
    logic          resp_err_q, resp_err_d;
    logic [31:0]   resp_data_q, resp_data_d;

    logic [1:0]    lane;
    logic [IW-1:0] word_idx;
    logic          in_range;
    logic          misaligned;
    logic          typ_ok;
    logic          req_err;
    logic          mem_we;
    logic [3:0]    byte_en;
    logic [31:0]   wr_word;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    // Decode: range, alignment, lane enables, load extraction.
    always_comb begin
        lane       = io_req_bits_addr[1:0];
        word_idx   = io_req_bits_addr[AW-1:2];
        in_range   = ((io_req_bits_addr ^ BASE_ADDR) & HI_MASK) == 32'd0;
        misaligned = 1'b0;
        typ_ok     = 1'b1;
        byte_en    = 4'b0000;
        wr_word    = 32'd0;
        load_val   = 32'd0;
        rd_word    = mem[word_idx];
        rd_byte    = rd_word[{lane, 3'b000} +: 8];
        rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];

        case (io_req_bits_typ)
            TYP_B, TYP_BU: begin
                byte_en  = 4'b0001 << lane;
                wr_word  = {4{io_req_bits_data[7:0]}};
                load_val = (io_req_bits_typ == TYP_B) ? {{24{rd_byte[7]}}, rd_byte}
                                                      : {24'd0, rd_byte};
            end
            TYP_H, TYP_HU: begin
                misaligned = lane[0];
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                wr_word    = {2{io_req_bits_data[15:0]}};
                load_val   = (io_req_bits_typ == TYP_H) ? {{16{rd_half[15]}}, rd_half}
                                                        : {16'd0, rd_half};
            end
            TYP_W: begin
                misaligned = lane != 2'd0;
                byte_en    = 4'b1111;
                wr_word    = io_req_bits_data;
                load_val   = rd_word;
            end
            default: typ_ok = 1'b0;
        endcase

        req_err = !in_range || misaligned || !typ_ok;
        mem_we  = io_req_valid && io_req_bits_fcn && !req_err && !reset;
    end

    // Response next-state: data only moves on reads (zero on an errored read).
    always_comb begin
        resp_valid_d = io_req_valid;
        resp_err_d   = io_req_valid && req_err;
        resp_data_d  = resp_data_q;
        if (io_req_valid && !io_req_bits_fcn) begin
            resp_data_d = req_err ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    assign io_resp_valid     = resp_valid_q;
    assign io_resp_err       = resp_err_q;
    assign io_resp_bits_data = resp_data_q;

endmodule

// File: tb/tb_sodor_scratchpad_2stage.sv
// Directed vector bench for sodor_scratchpad_2stage: table of back-to-back
// requests plus hand-written reset sequences.
module tb_sodor_scratchpad_2stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        req_fcn;
    logic [2:0]  req_typ;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    sodor_scratchpad_2stage dut (
        .clock             (clock),
        .reset             (reset),
        .io_req_valid      (req_valid),
        .io_req_bits_addr  (req_addr),
        .io_req_bits_data  (req_data),
        .io_req_bits_fcn   (req_fcn),
        .io_req_bits_typ   (req_typ),
        .io_resp_valid     (resp_valid),
        .io_resp_bits_data (resp_data),
        .io_resp_err       (resp_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        fcn;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                                input logic [31:0] data, input logic exp_err,
                                input logic [31:0] exp_rd);
        vec_t v;
        v.fcn = fcn; v.typ = typ; v.addr = addr; v.data = data;
        v.exp_err = exp_err; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] data);
        req_valid = v; req_fcn = fcn; req_typ = typ; req_addr = addr; req_data = data;
    endtask

    initial begin
        logic [31:0] last_rd;
        string       tag;

        // W=3 B=1 H=2 BU=5 HU=6; fcn 1=write. exp_rd only used for reads.
        vecs.push_back(mk(1, 3, 32'h8000_0010, 32'h1122_3344, 0, 0));
        vecs.push_back(mk(1, 1, 32'h8000_0011, 32'h0000_00AA, 0, 0));
        vecs.push_back(mk(0, 3, 32'h8000_0010, 0, 0, 32'h1122_AA44));
        vecs.push_back(mk(0, 1, 32'h8000_0011, 0, 0, 32'hFFFF_FFAA));
        vecs.push_back(mk(0, 5, 32'h8000_0011, 0, 0, 32'h0000_00AA));
        vecs.push_back(mk(0, 6, 32'h8000_0010, 0, 0, 32'h0000_AA44));
        vecs.push_back(mk(0, 2, 32'h8000_0010, 0, 0, 32'hFFFF_AA44));
        vecs.push_back(mk(0, 1, 32'h8000_0013, 0, 0, 32'h0000_0011));
        vecs.push_back(mk(1, 3, 32'h8000_0020, 32'h0000_0000, 0, 0));
        vecs.push_back(mk(1, 2, 32'h8000_0022, 32'hFFFF_8001, 0, 0));
        vecs.push_back(mk(0, 6, 32'h8000_0022, 0, 0, 32'h0000_8001));
        vecs.push_back(mk(0, 2, 32'h8000_0022, 0, 0, 32'hFFFF_8001));
        vecs.push_back(mk(0, 3, 32'h8000_0020, 0, 0, 32'h8001_0000));
        vecs.push_back(mk(1, 3, 32'h8000_0040, 32'h0000_0005, 0, 0));
        vecs.push_back(mk(0, 3, 32'h8000_0040, 0, 0, 32'h0000_0005));
        vecs.push_back(mk(0, 3, 32'h8004_0000, 0, 1, 32'h0000_0000));
        vecs.push_back(mk(0, 3, 32'h7FFF_FFFC, 0, 1, 32'h0000_0000));
        vecs.push_back(mk(1, 3, 32'h8000_0000, 32'hCAFE_F00D, 0, 0));
        vecs.push_back(mk(1, 2, 32'h8000_0001, 32'h0000_1234, 1, 0));
        vecs.push_back(mk(0, 3, 32'h8000_0000, 0, 0, 32'hCAFE_F00D));
        vecs.push_back(mk(0, 4, 32'h8000_0000, 0, 1, 32'h0000_0000));
        vecs.push_back(mk(0, 3, 32'h8000_0002, 0, 1, 32'h0000_0000));
        vecs.push_back(mk(1, 1, 32'h8000_0013, 32'h0000_0080, 0, 0));
        vecs.push_back(mk(0, 5, 32'h8000_0013, 0, 0, 32'h0000_0080));
        vecs.push_back(mk(0, 1, 32'h8000_0013, 0, 0, 32'hFFFF_FF80));
        vecs.push_back(mk(1, 7, 32'h8000_0010, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk(1, 0, 32'h8000_0010, 32'hFFFF_FFFF, 1, 0));
        vecs.push_back(mk(0, 3, 32'h8000_0010, 0, 0, 32'h8022_AA44));
        vecs.push_back(mk(1, 3, 32'h8003_FFFC, 32'h1357_9BDF, 0, 0));
        vecs.push_back(mk(0, 3, 32'h8003_FFFC, 0, 0, 32'h1357_9BDF));
        vecs.push_back(mk(1, 3, 32'h8004_0000, 32'h0BAD_0BAD, 1, 0));
        vecs.push_back(mk(0, 3, 32'h8000_0000, 0, 0, 32'hCAFE_F00D));

        // Request held through two reset cycles must be dropped.
        reset = 1'b1;
        drive(1, 1, 3'd3, 32'h8000_0000, 32'hDEAD_BEEF);
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk($sformatf("reset_valid[%0d]", c), 32'(resp_valid), 32'd0);
            chk($sformatf("reset_data[%0d]", c), resp_data, 32'd0);
            chk($sformatf("reset_err[%0d]", c), 32'(resp_err), 32'd0);
        end
        reset = 1'b0;
        drive(1, 0, 3'd3, 32'h8000_0000, 32'd0);
        @(negedge clock);
        chk("post_reset_rd_valid", 32'(resp_valid), 32'd1);
        chk("post_reset_rd_err", 32'(resp_err), 32'd0);
        checks++;
        if (resp_data === 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL post_reset_rd_data: got=%h expected anything but deadbeef", resp_data);
        end
        last_rd = resp_data;
        drive(0, 0, 3'd3, 32'd0, 32'd0);
        @(negedge clock);
        chk("idle_valid_low", 32'(resp_valid), 32'd0);
        chk("idle_data_hold", resp_data, last_rd);

        // Back-to-back table: row i checked one cycle after it is driven.
        for (int i = 0; i <= vecs.size(); i++) begin
            if (i < vecs.size()) begin
                drive(1, vecs[i].fcn, vecs[i].typ, vecs[i].addr, vecs[i].data);
            end else begin
                drive(0, 0, 3'd3, 32'd0, 32'd0);
            end
            @(negedge clock);
            if (i < vecs.size()) begin
                tag = $sformatf("vec%0d_%s_%h", i, vecs[i].fcn ? "wr" : "rd", vecs[i].addr);
                if (!vecs[i].fcn) last_rd = vecs[i].exp_rd;
                chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
                chk({tag, "_err"}, 32'(resp_err), 32'(vecs[i].exp_err));
                chk({tag, "_data"}, resp_data, last_rd);
            end else begin
                chk("tail_valid_low", 32'(resp_valid), 32'd0);
                chk("tail_err_low", 32'(resp_err), 32'd0);
            end
        end

        // Reset in the middle of traffic: write during reset is dropped, outputs clear.
        drive(1, 1, 3'd3, 32'h8000_0050, 32'h0000_0011);
        @(negedge clock);
        chk("mid_wr_valid", 32'(resp_valid), 32'd1);
        drive(1, 0, 3'd3, 32'h8000_0050, 32'd0);
        @(negedge clock);
        chk("mid_rd_data", resp_data, 32'h0000_0011);
        reset = 1'b1;
        drive(1, 1, 3'd3, 32'h8000_0050, 32'h0000_0077);
        @(negedge clock);
        chk("mid_reset_valid", 32'(resp_valid), 32'd0);
        chk("mid_reset_data", resp_data, 32'd0);
        chk("mid_reset_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        drive(1, 0, 3'd3, 32'h8000_0050, 32'd0);
        @(negedge clock);
        chk("mid_after_valid", 32'(resp_valid), 32'd1);
        chk("mid_after_data", resp_data, 32'h0000_0011);
        drive(0, 0, 3'd3, 32'd0, 32'd0);
        @(negedge clock);
        chk("final_valid_low", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
